// File: rtl/param_reg_file.sv
// Parameterised ARM-style register bank with three read ports, one write port,
// a dedicated PC (load / increment / read offset) and an NZCV flags register.
//
// Ports:
//   Clk, RESET                  clock, async active-high reset
//   LOAD, wr_sel, wr_data       general register write
//   LOADPC, pc_in, pc_inc       PC branch load and auto-increment
//   rn_sel/rm_sel/rs_sel        combinational read indices
//   Rn, Rm, Rs                  read data (PC index returns PC + PC_READ_OFS)
//   PCout                       raw PC value
//   flags_we, flags_in          NZCV write
//   flags_out                   stored NZCV
module param_reg_file #(
    parameter int WIDTH       = 32,
    parameter int NREGS       = 16,
    parameter int SEL_W       = 4,
    parameter int PC_IDX      = 15,
    parameter int PC_INC      = 4,
    parameter int PC_READ_OFS = 8,
    parameter int BYPASS      = 1
) (
    input  logic             Clk,
    input  logic             RESET,
    input  logic             LOAD,
    input  logic [SEL_W-1:0] wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             LOADPC,
    input  logic [WIDTH-1:0] pc_in,
    input  logic             pc_inc,
    input  logic [SEL_W-1:0] rn_sel,
    input  logic [SEL_W-1:0] rm_sel,
    input  logic [SEL_W-1:0] rs_sel,
    output logic [WIDTH-1:0] Rn,
    output logic [WIDTH-1:0] Rm,
    output logic [WIDTH-1:0] Rs,
    output logic [WIDTH-1:0] PCout,
    input  logic             flags_we,
    input  logic [3:0]       flags_in,
    output logic [3:0]       flags_out
);

    generate
        if (((1 << SEL_W) != NREGS) || (PC_IDX >= NREGS) || (NREGS < 4)
            || (NREGS > 64)) begin : g_bad_cfg
            $error("param_reg_file: inconsistent NREGS/SEL_W/PC_IDX");
        end
    endgenerate

    localparam logic [SEL_W-1:0] LP_PC  = SEL_W'(PC_IDX);
    localparam logic [WIDTH-1:0] LP_INC = WIDTH'(PC_INC);
    localparam logic [WIDTH-1:0] LP_OFS = WIDTH'(PC_READ_OFS);
    localparam bit               LP_BYP = (BYPASS != 0);

    logic [WIDTH-1:0] r_regs [NREGS];
    logic [WIDTH-1:0] r_pc;
    logic [3:0]       r_flags;

    logic w_wr_pc;
    logic w_wr_gpr;
    logic w_byp_en;

    assign w_wr_pc  = LOAD && (wr_sel == LP_PC);
    assign w_wr_gpr = LOAD && (wr_sel != LP_PC);
    // Forwarding is suppressed during reset so the ports read as cleared.
    assign w_byp_en = LP_BYP && w_wr_gpr && !RESET;

    // The PC slot of r_regs is never written; PC reads come from r_pc.
    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_gpr) begin
            r_regs[wr_sel] <= wr_data;
        end
    end

    // Branch load beats an ALU write to the PC index, which beats increment.
    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            r_pc <= '0;
        end else if (LOADPC) begin
            r_pc <= pc_in;
        end else if (w_wr_pc) begin
            r_pc <= wr_data;
        end else if (pc_inc) begin
            r_pc <= r_pc + LP_INC;
        end
    end

    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            r_flags <= '0;
        end else if (flags_we) begin
            r_flags <= flags_in;
        end
    end

    function automatic logic [WIDTH-1:0] f_read(input logic [SEL_W-1:0] sel);
        if (sel == LP_PC) begin
            return r_pc + LP_OFS;
        end else if (w_byp_en && (sel == wr_sel)) begin
            return wr_data;
        end else begin
            return r_regs[sel];
        end
    endfunction

    always_comb begin
        Rn = f_read(rn_sel);
        Rm = f_read(rm_sel);
        Rs = f_read(rs_sel);
    end

    assign PCout     = r_pc;
    assign flags_out = r_flags;

endmodule

// File: tb/tb_param_reg_file.sv
// Randomised plus directed bench for param_reg_file: two 32-bit instances
// (with and without bypass) against an architectural model, and a 16-bit one.
module tb_param_reg_file;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        RESET = 1'b0;
    logic        LOAD = 1'b0, LOADPC = 1'b0, pc_inc = 1'b0, flags_we = 1'b0;
    logic [3:0]  wr_sel = '0, rn_sel = '0, rm_sel = '0, rs_sel = '0;
    logic [3:0]  flags_in = '0;
    logic [31:0] wr_data = '0, pc_in = '0;

    logic [31:0] rn1, rm1, rs1, pc1, rn0, rm0, rs0, pc0;
    logic [3:0]  fl1, fl0;

    logic        g_load = 1'b0, g_loadpc = 1'b0, g_inc = 1'b0, g_fwe = 1'b0;
    logic [2:0]  g_wsel = '0, g_rn = '0, g_rm = '0, g_rs = '0;
    logic [15:0] g_wdata = '0, g_pcin = '0;
    logic [3:0]  g_fin = '0;
    logic [15:0] g_rnd, g_rmd, g_rsd, g_pc;
    logic [3:0]  g_fl;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    param_reg_file #(.BYPASS(1)) d_byp (
        .Clk(Clk), .RESET(RESET), .LOAD(LOAD), .wr_sel(wr_sel),
        .wr_data(wr_data), .LOADPC(LOADPC), .pc_in(pc_in), .pc_inc(pc_inc),
        .rn_sel(rn_sel), .rm_sel(rm_sel), .rs_sel(rs_sel),
        .Rn(rn1), .Rm(rm1), .Rs(rs1), .PCout(pc1),
        .flags_we(flags_we), .flags_in(flags_in), .flags_out(fl1)
    );

    param_reg_file #(.BYPASS(0)) d_nob (
        .Clk(Clk), .RESET(RESET), .LOAD(LOAD), .wr_sel(wr_sel),
        .wr_data(wr_data), .LOADPC(LOADPC), .pc_in(pc_in), .pc_inc(pc_inc),
        .rn_sel(rn_sel), .rm_sel(rm_sel), .rs_sel(rs_sel),
        .Rn(rn0), .Rm(rm0), .Rs(rs0), .PCout(pc0),
        .flags_we(flags_we), .flags_in(flags_in), .flags_out(fl0)
    );

    param_reg_file #(
        .WIDTH(16), .NREGS(8), .SEL_W(3), .PC_IDX(7), .PC_INC(2)
    ) d_gen (
        .Clk(Clk), .RESET(RESET), .LOAD(g_load), .wr_sel(g_wsel),
        .wr_data(g_wdata), .LOADPC(g_loadpc), .pc_in(g_pcin), .pc_inc(g_inc),
        .rn_sel(g_rn), .rm_sel(g_rm), .rs_sel(g_rs),
        .Rn(g_rnd), .Rm(g_rmd), .Rs(g_rsd), .PCout(g_pc),
        .flags_we(g_fwe), .flags_in(g_fin), .flags_out(g_fl)
    );

    // Architectural state of the 32-bit configuration.
    logic [31:0] m_r [16];
    logic [31:0] m_pc;
    logic [3:0]  m_fl;

    function automatic logic [31:0] next_pc();
        if (LOADPC)                       return pc_in;
        if (LOAD && wr_sel == 4'd15)      return wr_data;
        if (pc_inc)                       return m_pc + 32'd4;
        return m_pc;
    endfunction

    always @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 16; i++) m_r[i] <= '0;
            m_pc <= '0;
            m_fl <= '0;
        end else begin
            if (LOAD && wr_sel != 4'd15) m_r[wr_sel] <= wr_data;
            m_pc <= next_pc();
            if (flags_we) m_fl <= flags_in;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [3:0] s, input bit byp);
        if (s == 4'd15) return m_pc + 32'd8;
        if (byp && !RESET && LOAD && s == wr_sel) return wr_data;
        return m_r[s];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("rn_byp", rn1, exp_rd(rn_sel, 1'b1));
            chk("rm_byp", rm1, exp_rd(rm_sel, 1'b1));
            chk("rs_byp", rs1, exp_rd(rs_sel, 1'b1));
            chk("pc_byp", pc1, m_pc);
            chk("fl_byp", {28'd0, fl1}, {28'd0, m_fl});
            chk("rn_nob", rn0, exp_rd(rn_sel, 1'b0));
            chk("rm_nob", rm0, exp_rd(rm_sel, 1'b0));
            chk("rs_nob", rs0, exp_rd(rs_sel, 1'b0));
            chk("pc_nob", pc0, m_pc);
            chk("fl_nob", {28'd0, fl0}, {28'd0, m_fl});
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #1 RESET = 1'b1;
        step();
        step();
        rm_sel = 4'd15;
        #1;
        chk("rst_pc", pc1, 32'h0);
        chk("rst_rn0", rn1, 32'h0);
        chk("rst_rm15", rm1, 32'h8);
        chk("rst_fl", {28'd0, fl1}, 32'h0);
        step();
        RESET = 1'b0;
        chk_en = 1'b1;

        // Load R3, flags and bump PC, then hit reset mid-cycle.
        LOAD = 1'b1; wr_sel = 4'd3; wr_data = 32'h1234;
        flags_we = 1'b1; flags_in = 4'hF; pc_inc = 1'b1;
        step();
        LOAD = 1'b0; flags_we = 1'b0; pc_inc = 1'b0;
        rn_sel = 4'd3; rm_sel = 4'd15;
        #1;
        chk("pre_rst_r3", rn1, 32'h1234);
        chk("pre_rst_pc", pc1, 32'h4);
        chk("pre_rst_rm15", rm1, 32'hC);
        RESET = 1'b1;
        LOAD = 1'b1; wr_sel = 4'd4; wr_data = 32'h77;
        #1;
        chk("mid_rst_r3", rn1, 32'h0);
        chk("mid_rst_rm15", rm1, 32'h8);
        chk("mid_rst_pc", pc1, 32'h0);
        chk("mid_rst_fl", {28'd0, fl1}, 32'h0);
        step();
        step();
        RESET = 1'b0; LOAD = 1'b0;
        rn_sel = 4'd4;
        #1;
        chk("rst_drops_wr", rn1, 32'h0);

        // Fill R0..R14 and read back on every port.
        for (int i = 0; i < 15; i++) begin
            LOAD = 1'b1; wr_sel = 4'(i); wr_data = 32'hA5A50000 + i;
            step();
        end
        LOAD = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rn_sel = 4'(i); rm_sel = 4'(i); rs_sel = 4'(i);
            #1;
            if (i < 15) begin
                chk("fill_rn", rn1, 32'hA5A50000 + i);
                chk("fill_rm", rm1, 32'hA5A50000 + i);
                chk("fill_rs", rs0, 32'hA5A50000 + i);
            end else begin
                chk("fill_rs15", rs1, 32'h8);
                chk("fill_pc", pc1, 32'h0);
            end
        end

        // PC wrap and update priority.
        rn_sel = 4'd15;
        LOADPC = 1'b1; pc_in = 32'hFFFF_FFFC;
        step();
        LOADPC = 1'b0;
        #1;
        chk("pc_rd_wrap", rn1, 32'h4);
        pc_inc = 1'b1;
        step();
        pc_inc = 1'b0;
        chk("pc_inc_wrap", pc1, 32'h0);
        chk("pc_rd_after", rn1, 32'h8);
        LOADPC = 1'b1; pc_in = 32'h100;
        LOAD = 1'b1; wr_sel = 4'd15; wr_data = 32'h200; pc_inc = 1'b1;
        step();
        LOADPC = 1'b0;
        chk("pc_prio_load", pc1, 32'h100);
        wr_data = 32'h300;
        step();
        LOAD = 1'b0; pc_inc = 1'b0;
        chk("pc_prio_wr", pc1, 32'h300);

        // Bypass versus stored read.
        rn_sel = 4'd5;
        LOAD = 1'b1; wr_sel = 4'd5; wr_data = 32'hDEAD;
        #1;
        chk("byp_same_cyc", rn1, 32'hDEAD);
        chk("nob_same_cyc", rn0, 32'hA5A50005);
        step();
        LOAD = 1'b0;
        #1;
        chk("nob_after", rn0, 32'hDEAD);

        // Flags hold when not written.
        flags_we = 1'b1; flags_in = 4'b1010;
        step();
        chk("flags_wr", {28'd0, fl1}, 32'hA);
        flags_we = 1'b0; flags_in = 4'b0101;
        step();
        chk("flags_hold", {28'd0, fl1}, 32'hA);

        // Randomised traffic, model checked every negedge.
        for (int n = 0; n < 600; n++) begin
            RESET    = ($urandom_range(0, 63) == 0);
            LOAD     = 1'($urandom);
            wr_sel   = 4'($urandom);
            wr_data  = $urandom;
            LOADPC   = ($urandom_range(0, 7) == 0);
            pc_in    = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFF8 : $urandom;
            pc_inc   = 1'($urandom);
            rn_sel   = 4'($urandom);
            rm_sel   = 4'($urandom);
            rs_sel   = ($urandom_range(0, 3) == 0) ? wr_sel : 4'($urandom);
            flags_we = 1'($urandom);
            flags_in = 4'($urandom);
            step();
        end
        RESET = 1'b0; LOAD = 1'b0; LOADPC = 1'b0; pc_inc = 1'b0;
        flags_we = 1'b0;
        step();

        // 16-bit, 8-register configuration.
        g_load = 1'b1; g_wsel = 3'd6; g_wdata = 16'hBEEF;
        step();
        g_load = 1'b0; g_rn = 3'd6; g_rm = 3'd7;
        #1;
        chk("gen_r6", {16'd0, g_rnd}, 32'hBEEF);
        g_loadpc = 1'b1; g_pcin = 16'hFFFE;
        step();
        g_loadpc = 1'b0;
        chk("gen_pc_ld", {16'd0, g_pc}, 32'hFFFE);
        chk("gen_pc_rd", {16'd0, g_rmd}, 32'h0006);
        g_inc = 1'b1;
        step();
        g_inc = 1'b0;
        chk("gen_pc_wrap", {16'd0, g_pc}, 32'h0);
        chk("gen_pc_rd2", {16'd0, g_rmd}, 32'h0008);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/param_reg_file.md
Name: param_reg_file

Overview:
- Parameterised successor to the fixed 16x32 register file feeding the ARM ALU.
- Provides a configurable-depth, configurable-width general register bank with three combinational read ports (Rn, Rm, Rs) and one synchronous write port.
- Includes a dedicated program counter register with load/auto-increment, an ARM-style PC read offset, optional write-to-read bypass, and a 4-bit NZCV flags register.
- Sits between the instruction decoder/control unit and the ALU in the CPU datapath.

Parameters:
- WIDTH, 32, data/register width in bits.
- NREGS, 16, number of architectural registers including the PC; power of two, 4..64.
- SEL_W, 4, register-select width; must equal log2(NREGS).
- PC_IDX, 15, register index aliased to the program counter.
- PC_INC, 4, amount added to the PC on pc_inc.
- PC_READ_OFS, 8, offset added to the PC value when it is read through Rn/Rm/Rs.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value.

Ports:
- Clk  in  1  system clock, rising edge active.
- RESET  in  1  asynchronous, active-high reset.
- LOAD  in  1  general write enable.
- wr_sel  in  SEL_W  write register index.
- wr_data  in  WIDTH  write data (ALU result).
- LOADPC  in  1  PC load enable (branch target).
- pc_in  in  WIDTH  PC load value.
- pc_inc  in  1  PC auto-increment enable.
- rn_sel, rm_sel, rs_sel  in  SEL_W each  read indices.
- Rn, Rm, Rs  out  WIDTH each  read data.
- PCout  out  WIDTH  raw PC value (no offset).
- flags_we  in  1  flags write enable (ALU S bit).
- flags_in  in  4  NZCV from ALU.
- flags_out  out  4  stored NZCV.

Behaviour:
- Reset: RESET high asynchronously clears all NREGS registers, PC, and flags to 0. PCout = 0, flags_out = 0, and Rn/Rm/Rs = 0, except a PC read returns PC_READ_OFS.
- While RESET is high, all writes are ignored. Release is synchronous to the next rising edge. A mid-operation reset discards any in-flight write.
- Write: on a rising Clk edge with LOAD=1, reg[wr_sel] <= wr_data.
- PC update priority, highest first, on each rising edge:
  - LOADPC → PC <= pc_in
  - LOAD with wr_sel==PC_IDX → PC <= wr_data
  - pc_inc → PC <= PC + PC_INC (mod 2^WIDTH, wraps silently)
  - otherwise hold.
- Simultaneous LOADPC and LOAD to PC_IDX: LOADPC wins, the wr_data write is dropped. A LOAD to a non-PC index proceeds in parallel with any PC update.
- Reads are combinational, with zero latency:
  - sel != PC_IDX → reg[sel]
  - sel == PC_IDX → PC + PC_READ_OFS (mod 2^WIDTH).
- Bypass (BYPASS=1): if LOAD=1, sel == wr_sel, and sel != PC_IDX, the port returns wr_data in the same cycle. PC reads are never bypassed; they always reflect the stored PC plus offset.
- With BYPASS=0, the read returns the old value until after the edge.
- All three read ports are independent; the same index on multiple ports is legal.
- Flags: on a rising edge with flags_we=1, flags <= flags_in; otherwise hold. There is no bypass on flags_out.
- Out-of-range indices are impossible because NREGS = 2^SEL_W; elaboration must fail if SEL_W != log2(NREGS) or PC_IDX >= NREGS.
- Pure storage block: no arithmetic other than the PC increment and the read offset.

Test Plan:
1. Reset check: assert RESET mid-cycle after loading R3=0x1234. Required response:
   - Rn(sel 3) = 0 immediately, without waiting for a clock edge.
   - PCout = 0, and Rm(sel 15) = 8.
   - flags_out = 0.
2. Write/read all registers: write reg i = 0xA5A50000+i for i=0..14, then read each index on all three ports. Required response:
   - Each port returns the exact value.
   - Rs(sel 15) = PCout+8.
3. PC priority and wrap: set PC=0xFFFFFFFC and pulse pc_inc, giving PC=0x00000000. Then, in one cycle, drive LOADPC=1 with pc_in=0x100, LOAD=1 with wr_sel=15 and wr_data=0x200, and pc_inc=1. Required response: PCout = 0x100.
4. Bypass: with BYPASS=1, LOAD=1, wr_sel=5, wr_data=0xDEAD and rn_sel=5 in the same cycle, Rn = 0xDEAD before the edge. Repeat with BYPASS=0: Rn = old value before the edge and 0xDEAD after it.
5. Flags: flags_we=1 with flags_in=4'b1010 gives flags_out = 1010. Then flags_we=0 with flags_in=4'b0101 leaves flags_out = 1010.
6. Generic configuration: WIDTH=16, NREGS=8, SEL_W=3, PC_IDX=7, PC_INC=2. Required response:
   - Writing R6=0xBEEF reads back 0xBEEF.
   - PC wraps from 0xFFFE to 0x0000 on pc_inc.
